// File: rtl/dma_channel_arbiter.sv
// Four-channel DMA request arbiter: qualifies DREQ, picks a channel by fixed or
// rotating priority, holds the grant through service and drives DACK.
module dma_channel_arbiter #(
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic [NCH-1:0] DREQ,
  input  logic [NCH-1:0] mask,
  input  logic           cmd_ctrl_dis,
  input  logic           cmd_rot_pri,
  input  logic           cmd_dreq_low,
  input  logic           cmd_dack_high,
  input  logic           sw_req_set,
  input  logic           sw_req_clr,
  input  logic [CW-1:0]  sw_req_ch,
  input  logic           svc_ack,
  input  logic           svc_done,
  input  logic           tc,
  input  logic           EOP_N,
  output logic           hrq_req,
  output logic [NCH-1:0] valid_dreq,
  output logic [CW-1:0]  grant_ch,
  output logic [NCH-1:0] DACK,
  output logic [NCH-1:0] req_status,
  output logic           busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_SVC  = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  grant_q, grant_d;
  logic [NCH-1:0] valid_q, valid_d;
  logic [NCH-1:0] swreq_q, swreq_d;
  logic [CW-1:0]  hi_q, hi_d;

  logic [NCH-1:0] pend;
  logic [NCH-1:0] eff;
  logic [CW-1:0]  hi_arb;
  logic [CW-1:0]  win;
  logic [CW-1:0]  idx;
  logic           svc_end;

  assign pend   = ((DREQ ^ {NCH{cmd_dreq_low}}) & ~mask) | swreq_q;
  assign eff    = pend & ~{NCH{cmd_ctrl_dis}};
  assign hi_arb = cmd_rot_pri ? hi_q : '0;

  // Scan from the farthest candidate back to hi so the nearest set bit wins.
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = CW'((int'(hi_arb) + k) % NCH);
      if (eff[idx]) win = idx;
    end
  end

  assign svc_end = (state_q == S_SVC) && (svc_done || !EOP_N);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    valid_d = valid_q;
    hi_d    = hi_q;
    swreq_d = swreq_q;

    if (sw_req_set) swreq_d[sw_req_ch] = 1'b1;
    if (sw_req_clr) swreq_d[sw_req_ch] = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|eff) begin
          state_d       = S_REQ;
          grant_d       = win;
          valid_d       = '0;
          valid_d[win]  = 1'b1;
        end
      end
      S_REQ: begin
        if (svc_ack) begin
          state_d = S_SVC;
        end else if (!EOP_N || !eff[grant_q]) begin
          state_d = S_IDLE;
          grant_d = '0;
          valid_d = '0;
        end
      end
      S_SVC: begin
        if (svc_end) begin
          state_d = S_IDLE;
          grant_d = '0;
          valid_d = '0;
          if (cmd_rot_pri) hi_d = CW'((int'(grant_q) + 1) % NCH);
          if ((svc_done && tc) || !EOP_N) swreq_d[grant_q] = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        valid_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      valid_q <= '0;
      swreq_q <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      swreq_q <= swreq_d;
      hi_q    <= hi_d;
    end
  end

  assign hrq_req    = (state_q == S_REQ) || (state_q == S_SVC);
  assign busy       = hrq_req;
  assign valid_dreq = valid_q;
  assign grant_ch   = grant_q;
  assign req_status = pend;
  assign DACK       = {NCH{~cmd_dack_high}} ^ ({NCH{state_q == S_SVC}} & valid_q);

endmodule
